// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes SCK/WS/SD into clk_i, assembles MSB-first stereo
// words and hands out one left/right pair per frame on a valid/ready interface.
module i2s_rx #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned SLOT_WIDTH  = 32,
  parameter logic        WS_POL      = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic [DATA_WIDTH-1:0] sample_left_o,
  output logic [DATA_WIDTH-1:0] sample_right_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  overrun_o,
  output logic                  frame_err_o
);

  localparam int unsigned CNT_W = $clog2(SLOT_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
  logic                   sck_s, ws_s, sd_s;
  logic                   sck_prev, ws_prev;
  logic                   rise, ws_change;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  left_sr, right_sr, right_next;
  logic                   shift_left, shift_right, pair_done, frame_err;

  // Input synchronizers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_i};
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign ws_s      = ws_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign rise      = sck_s & ~sck_prev;
  assign ws_change = rise & (ws_s != ws_prev);

  // SCK edge history, WS at last rise, saturating bit counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_prev <= 1'b0;
      ws_prev  <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      sck_prev <= sck_s;
      if (rise) begin
        ws_prev <= ws_s;
        if (ws_change) begin
          bit_cnt <= '0;
        end else if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Slot tracking; the WS-change rise carries the old slot's last (pad) bit
  always_comb begin
    state_nxt   = state;
    shift_left  = 1'b0;
    shift_right = 1'b0;
    pair_done   = 1'b0;
    frame_err   = 1'b0;
    if (rise) begin
      case (state)
        ST_SYNC: begin
          if (ws_change && (ws_s == WS_POL)) begin
            state_nxt = ST_LEFT;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (ws_change) begin
            if (bit_cnt < CNT_DATA) begin
              frame_err = 1'b1;
              state_nxt = ST_SYNC;
            end else if ((state == ST_LEFT) && (ws_s != WS_POL)) begin
              state_nxt = ST_RIGHT;
            end else if ((state == ST_RIGHT) && (ws_s == WS_POL)) begin
              state_nxt = ST_LEFT;
            end
          end else begin
            if (bit_cnt < CNT_DATA) begin
              shift_left  = (state == ST_LEFT);
              shift_right = (state == ST_RIGHT);
            end
            pair_done = (state == ST_RIGHT) && (bit_cnt == CNT_LAST);
            if (bit_cnt == CNT_SLOT) begin
              frame_err = 1'b1;
              state_nxt = ST_SYNC;
            end
          end
        end
        default: state_nxt = ST_SYNC;
      endcase
    end
  end

  assign right_next = (right_sr << 1) | DATA_WIDTH'(sd_s);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      left_sr  <= '0;
      right_sr <= '0;
    end else begin
      if (shift_left) begin
        left_sr <= (left_sr << 1) | DATA_WIDTH'(sd_s);
      end
      if (shift_right) begin
        right_sr <= right_next;
      end
    end
  end

  // Output pair register with valid/ready handshake and overrun detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_left_o  <= '0;
      sample_right_o <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      overrun_o   <= 1'b0;
      frame_err_o <= frame_err;
      if (pair_done) begin
        if (!sample_valid_o || sample_ready_i) begin
          sample_left_o  <= left_sr;
          sample_right_o <= right_next;
          sample_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (sample_valid_o && sample_ready_i) begin
        sample_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: I2S master BFM, scoreboard of expected pairs,
// pulse counters for overrun/frame error.
module tb_i2s_rx;

  localparam int unsigned DW = 24;
  localparam int unsigned SW = 32;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst, sck, ws, sd, ready;
  logic [DW-1:0] left, right;
  logic          valid, overrun, frame_err;

  always #5 clk = ~clk;

  i2s_rx #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .WS_POL(1'b0), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .sample_left_o(left), .sample_right_o(right), .sample_valid_o(valid),
    .sample_ready_i(ready), .overrun_o(overrun), .frame_err_o(frame_err)
  );

  int    errors = 0;
  int    checks = 0;
  int    cycle = 0;
  int    ovr_cnt = 0;
  int    ferr_cnt = 0;
  int    hs_times[$];
  pair_t exp_q[$];
  pair_t mon_p;
  logic  last_bit = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  // Monitor: pulse counts and scoreboard pops at each handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) ovr_cnt++;
      if (frame_err) ferr_cnt++;
      if (valid && ready) begin
        hs_times.push_back(cycle);
        check("pair_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_p = exp_q.pop_front();
          check("left", 64'(left), 64'(mon_p.l));
          check("right", 64'(right), 64'(mon_p.r));
        end
      end
    end
  end

  function automatic logic stream_bit(input logic [DW-1:0] word, input logic pad, input int j);
    if (j < int'(DW)) return word[DW-1-j];
    return pad;
  endfunction

  // One SCK period (4 clk low, 4 clk high); optional 1-cycle ready pulse
  // aligned with the DUT's detected rise of this bit (2 sync stages).
  task automatic sck_bit(input logic w, input logic d, input bit mark);
    sck = 1'b0; ws = w; sd = d;
    repeat (4) begin @(posedge clk); #2; end
    sck = 1'b1;
    if (mark) begin
      @(posedge clk); #2;
      @(posedge clk); #2; ready = 1'b1;
      @(posedge clk); #2; ready = 1'b0;
      @(posedge clk); #2;
    end else begin
      repeat (4) begin @(posedge clk); #2; end
    end
  endtask

  task automatic send_slot(input logic w, input logic [DW-1:0] word, input logic pad,
                           input int nsck, input int mark_k);
    logic d;
    for (int k = 0; k < nsck; k++) begin
      d = (k == 0) ? last_bit : stream_bit(word, pad, k - 1);
      sck_bit(w, d, k == mark_k);
    end
    last_bit = stream_bit(word, pad, nsck - 1);
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic pad,
                            input bit push, input int mark_k);
    pair_t p;
    p.l = l;
    p.r = r;
    if (push) exp_q.push_back(p);
    send_slot(1'b0, l, pad, SW, -1);
    send_slot(1'b1, r, pad, SW, mark_k);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int base_hs, base_ovr, base_ferr;

  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b1; sd = 1'b0; ready = 1'b0;
    wait_cycles(4);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_left", 64'(left), 64'd0);
    rst = 1'b0;

    // Reset mid-frame while a pair is held
    send_slot(1'b1, 24'h0, 1'b0, SW, -1);
    send_frame(24'h111111, 24'h222222, 1'b0, 1'b0, -1);
    send_slot(1'b0, 24'h333333, 1'b0, SW, -1);
    send_slot(1'b1, 24'h444444, 1'b0, 10, -1);
    check("pre_rst_valid", 64'(valid), 64'd1);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    check("post_rst_valid", 64'(valid), 64'd0);
    check("post_rst_left", 64'(left), 64'd0);
    check("post_rst_right", 64'(right), 64'd0);
    check("post_rst_flags", 64'({overrun, frame_err}), 64'd0);
    send_slot(1'b1, 24'h444444, 1'b0, SW - 10, -1);
    ready = 1'b1;
    send_frame(24'hC0FFEE, 24'h0BEEF0, 1'b0, 1'b1, -1);

    // Steady stream, one pair per 512 clk
    base_hs = hs_times.size();
    base_ovr = ovr_cnt;
    base_ferr = ferr_cnt;
    repeat (3) send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b1, -1);
    check("stream_pairs", 64'(hs_times.size() - base_hs), 64'd3);
    if (hs_times.size() - base_hs == 3) begin
      check("period_1", 64'(hs_times[base_hs+1] - hs_times[base_hs]), 64'd512);
      check("period_2", 64'(hs_times[base_hs+2] - hs_times[base_hs+1]), 64'd512);
    end
    check("stream_flags", 64'((ovr_cnt - base_ovr) + (ferr_cnt - base_ferr)), 64'd0);

    // Backpressure over three frames
    ready = 1'b0;
    base_ovr = ovr_cnt;
    send_frame(24'h123456, 24'h654321, 1'b0, 1'b1, -1);
    send_frame(24'hDEAD00, 24'h00BEEF, 1'b0, 1'b0, -1);
    send_frame(24'hFFFFFF, 24'h000000, 1'b0, 1'b0, -1);
    check("overrun_pulses", 64'(ovr_cnt - base_ovr), 64'd2);
    check("held_valid", 64'(valid), 64'd1);
    check("held_left", 64'(left), 64'h123456);
    check("held_right", 64'(right), 64'h654321);
    ready = 1'b1;
    wait_cycles(4);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0, 1'b1, -1);

    // Short left slot
    base_ferr = ferr_cnt;
    send_slot(1'b0, 24'h777777, 1'b0, 11, -1);
    send_slot(1'b1, 24'h888888, 1'b0, SW, -1);
    check("short_slot_err", 64'(ferr_cnt - base_ferr), 64'd1);
    send_frame(24'h13579B, 24'h2468AC, 1'b0, 1'b1, -1);
    check("short_slot_recover", 64'(ferr_cnt - base_ferr), 64'd1);

    // Padding ignored; ready coincides with new pair completion
    ready = 1'b0;
    base_ovr = ovr_cnt;
    send_frame(24'h800001, 24'h0FF00F, 1'b1, 1'b1, -1);
    send_frame(24'h800001, 24'h400002, 1'b1, 1'b1, DW);
    check("coincide_overrun", 64'(ovr_cnt - base_ovr), 64'd0);
    check("coincide_valid", 64'(valid), 64'd1);
    check("coincide_right", 64'(right), 64'h400002);
    ready = 1'b1;
    wait_cycles(4);

    // Long slot: WS constant for 40 SCK
    base_ferr = ferr_cnt;
    send_slot(1'b0, 24'h999999, 1'b0, 40, -1);
    send_slot(1'b1, 24'hAAAAAA, 1'b0, SW, -1);
    send_frame(24'hFEDCBA, 24'hABCDEF, 1'b0, 1'b1, -1);
    check("long_slot_err", 64'(ferr_cnt - base_ferr), 64'd1);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
